// File: rtl/prog_load_ctrl.sv
// Program-download sequencer: holds the CPU, packs framed UART bytes into 32-bit imem words.
// Optional trailing XOR checksum byte is enabled by defining PROG_CHECKSUM_EN.
module prog_load_ctrl #(
  parameter int ADDR_W         = 14,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_pg,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int                TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_ONE  = TMO_W'(1);
  localparam logic [31:0]       N_MAX    = 32'd1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR_HI = 3'd1,
    S_HDR_LO = 3'd2,
    S_DATA   = 3'd3,
`ifdef PROG_CHECKSUM_EN
    S_CSUM   = 3'd4,
`endif
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic              start_q;
  logic [7:0]        hi_q, hi_d;
  logic [15:0]       n_q, n_d;
  logic [23:0]       sh_q, sh_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [16:0]       widx_q, widx_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              hold_q, hold_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
`ifdef PROG_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic        start_rise;
  logic        loading;
  logic        timed_out;
  logic        go_err;
  logic [15:0] n_rx;

  assign start_rise = start_pg & ~start_q;
  assign n_rx       = {hi_q, rx_data};

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    n_d       = n_q;
    sh_d      = sh_q;
    bcnt_d    = bcnt_q;
    widx_d    = widx_q;
    waddr_d   = waddr_q;
    tmo_d     = '0;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    hold_d    = hold_q;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
`ifdef PROG_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    timed_out = 1'b0;
    go_err    = 1'b0;

    loading = (state_q == S_HDR_HI) || (state_q == S_HDR_LO) || (state_q == S_DATA)
`ifdef PROG_CHECKSUM_EN
              || (state_q == S_CSUM)
`endif
              ;

    // Idle-gap watchdog: any received byte restarts the count.
    if (loading && !rx_valid) begin
      if (tmo_q == TMO_LAST) timed_out = 1'b1;
      else                   tmo_d     = tmo_q + TMO_ONE;
    end

    case (state_q)
      S_IDLE, S_ERR: begin
        if (start_rise) begin
          state_d = S_HDR_HI;
          busy_d  = 1'b1;
          hold_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          bcnt_d  = '0;
          widx_d  = '0;
          waddr_d = '0;
`ifdef PROG_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      S_HDR_HI: begin
        if (rx_valid) begin
          hi_d    = rx_data;
          state_d = S_HDR_LO;
        end
      end
      S_HDR_LO: begin
        if (rx_valid) begin
          n_d = n_rx;
          if (n_rx == 16'd0) begin
`ifdef PROG_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_DONE;
`endif
          end else if ({16'd0, n_rx} > N_MAX) begin
            go_err = 1'b1;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          sh_d   = {sh_q[15:0], rx_data};
          bcnt_d = bcnt_q + 2'd1;
`ifdef PROG_CHECKSUM_EN
          csum_d = csum_q ^ rx_data;
`endif
          if (bcnt_q == 2'd3) begin
            we_d    = 1'b1;
            wdata_d = {sh_q, rx_data};
            addr_d  = waddr_q;
            waddr_d = waddr_q + ADDR_W'(1);
            widx_d  = widx_q + 17'd1;
            if (widx_q + 17'd1 == {1'b0, n_q}) begin
`ifdef PROG_CHECKSUM_EN
              state_d = S_CSUM;
`else
              state_d = S_DONE;
`endif
            end
          end
        end
      end
`ifdef PROG_CHECKSUM_EN
      S_CSUM: begin
        if (rx_valid) begin
          if (rx_data == csum_q) state_d = S_DONE;
          else                   go_err  = 1'b1;
        end
      end
`endif
      S_DONE: begin
        busy_d  = 1'b0;
        hold_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // CPU stays held on failure so a partial image never runs.
    if (go_err || timed_out) begin
      state_d = S_ERR;
      busy_d  = 1'b0;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      hi_q    <= '0;
      n_q     <= '0;
      sh_q    <= '0;
      bcnt_q  <= '0;
      widx_q  <= '0;
      waddr_q <= '0;
      tmo_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      hold_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef PROG_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      start_q <= start_pg;
      hi_q    <= hi_d;
      n_q     <= n_d;
      sh_q    <= sh_d;
      bcnt_q  <= bcnt_d;
      widx_q  <= widx_d;
      waddr_q <= waddr_d;
      tmo_q   <= tmo_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef PROG_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_hold   = hold_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Scoreboard bench for prog_load_ctrl: expected imem writes are queued by the stimulus
// and checked by an independent monitor; status outputs are checked at fixed latencies.
module tb_prog_load_ctrl;
  localparam int ADDR_W = 14;
  localparam int TMO    = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_pg;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;

  always #5 clk = ~clk;

  prog_load_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .start_pg(start_pg), .rx_valid(rx_valid), .rx_data(rx_data),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
  );

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
  } wr_t;

  wr_t exp_q[$];
  int  n_vec = 0;
  int  n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write pulse must match the head of the expected-write queue.
  always @(negedge clk) begin
    wr_t e;
    if (rst === 1'b0 && imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: addr %h data %h, expected no write at %0t",
                 imem_addr, imem_wdata, $time);
      end else begin
        e = exp_q.pop_front();
        $display("write addr %h data %h", imem_addr, imem_wdata);
        check("wr_addr", 32'(imem_addr), 32'(e.a));
        check("wr_data", imem_wdata, e.d);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_start();
    @(negedge clk);
    start_pg = 1'b1;
    @(negedge clk);
    start_pg = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_burst(input logic [7:0] bs[$]);
    @(negedge clk);
    foreach (bs[i]) begin
      rx_valid = 1'b1;
      rx_data  = bs[i];
      @(negedge clk);
    end
    rx_valid = 1'b0;
  endtask

  task automatic load_frame(input logic [31:0] words[$], input bit burst);
    logic [7:0] bs[$];
`ifdef PROG_CHECKSUM_EN
    logic [7:0] cs = 8'h00;
`endif
    bs.push_back(8'(words.size() >> 8));
    bs.push_back(8'(words.size()));
    foreach (words[i]) begin
      exp_q.push_back('{a: ADDR_W'(i), d: words[i]});
      for (int k = 3; k >= 0; k--) begin
        bs.push_back(words[i][8*k +: 8]);
`ifdef PROG_CHECKSUM_EN
        cs = cs ^ words[i][8*k +: 8];
`endif
      end
    end
`ifdef PROG_CHECKSUM_EN
    bs.push_back(cs);
`endif
    if (burst) begin
      send_burst(bs);
    end else begin
      foreach (bs[j]) begin
        send_byte(bs[j]);
        if (j >= 2 && j < 2 + 4 * words.size() && (j - 2) % 4 == 3)
          check("we_latency", 32'(imem_we), 32'd1);
        if (j < bs.size() - 1) check("hold_during_load", 32'(cpu_hold), 32'd1);
      end
    end
    @(negedge clk);
    $display("frame of %0d words: done=%0b busy=%0b cpu_hold=%0b", words.size(), done, busy, cpu_hold);
    check("frame_done", 32'(done), 32'd1);
    check("frame_busy", 32'(busy), 32'd0);
    check("frame_hold", 32'(cpu_hold), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w[$];
    rst = 1'b1; start_pg = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    tick(2);
    // Reset state
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_flags", {28'd0, cpu_hold, busy, done, err}, 32'd0);
    rst = 1'b0;
    tick(1);

    // 1: two-word frame with gaps between bytes
    press_start();
    check("start_busy", 32'(busy), 32'd1);
    check("start_hold", 32'(cpu_hold), 32'd1);
    w = '{32'h12345678, 32'h9ABCDEF0};
    load_frame(w, 1'b0);
    tick(2);
    check("addr_hold", 32'(imem_addr), 32'd1);
    check("wdata_hold", imem_wdata, 32'h9ABCDEF0);
    check("done_sticky", 32'(done), 32'd1);

    // 2: empty image
    press_start();
    check("done_cleared", 32'(done), 32'd0);
    send_byte(8'h00);
    send_byte(8'h00);
`ifdef PROG_CHECKSUM_EN
    send_byte(8'h00);
`endif
    @(negedge clk);
    $display("empty frame: done=%0b cpu_hold=%0b", done, cpu_hold);
    check("n0_done", 32'(done), 32'd1);
    check("n0_hold", 32'(cpu_hold), 32'd0);

    // 3: inter-byte timeout
    press_start();
    send_byte(8'h00); send_byte(8'h01); send_byte(8'hAA); send_byte(8'hBB);
    tick(TMO - 1);
    check("tmo_early", 32'(err), 32'd0);
    tick(1);
    $display("timeout: err=%0b cpu_hold=%0b busy=%0b", err, cpu_hold, busy);
    check("tmo_err", 32'(err), 32'd1);
    check("tmo_hold", 32'(cpu_hold), 32'd1);
    check("tmo_busy", 32'(busy), 32'd0);

    // 4: reset mid-load, then reload back-to-back from address 0
    press_start();
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    $display("mid-load reset: flags=%b", {cpu_hold, busy, done, err});
    check("midrst_flags", {28'd0, cpu_hold, busy, done, err}, 32'd0);
    check("midrst_we", 32'(imem_we), 32'd0);
    rst = 1'b0;
    press_start();
    w = '{32'hA1B2C3D4, 32'h0F1E2D3C};
    load_frame(w, 1'b1);

    // 5: start_pg toggling during DATA is ignored
    press_start();
    send_byte(8'h00); send_byte(8'h01);
    exp_q.push_back('{a: ADDR_W'(0), d: 32'hCAFEF00D});
    start_pg = 1'b1; send_byte(8'hCA);
    start_pg = 1'b0; send_byte(8'hFE);
    start_pg = 1'b1; send_byte(8'hF0);
    start_pg = 1'b0; send_byte(8'h0D);
`ifdef PROG_CHECKSUM_EN
    send_byte(8'hC9);
`endif
    @(negedge clk);
    check("ign_done", 32'(done), 32'd1);
    tick(2);
    check("ign_no_restart", 32'(busy), 32'd0);

    // 5b: header just above and exactly at the memory depth
    press_start();
    send_byte(8'h40); send_byte(8'h01);
    $display("oversize header: err=%0b cpu_hold=%0b", err, cpu_hold);
    check("big_err", 32'(err), 32'd1);
    check("big_hold", 32'(cpu_hold), 32'd1);
    press_start();
    send_byte(8'h40); send_byte(8'h00);
    check("max_ok_err", 32'(err), 32'd0);
    check("max_ok_busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

`ifdef PROG_CHECKSUM_EN
    // 6: checksum match and mismatch
    press_start();
    exp_q.push_back('{a: ADDR_W'(0), d: 32'h01020304});
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h04);
    @(negedge clk);
    check("csum_ok_done", 32'(done), 32'd1);
    press_start();
    exp_q.push_back('{a: ADDR_W'(0), d: 32'h01020304});
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h05);
    check("csum_bad_err", 32'(err), 32'd1);
    check("csum_bad_hold", 32'(cpu_hold), 32'd1);
`endif

    tick(3);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
